tdoa_estimator: RTL and testbench
=================================

// Module: tdoa_estimator
// PURPOSE
//  Producer side of the TDOA interface consumed by the direction solver. Timestamps acoustic onsets
//  from mics A, B, C in sample ticks and emits signed delays dAB = tB - tA and dAC = tC - tA
//  with a one-cycle trigger. Sits between the per-mic envelope/onset detectors and the solver.
// PARAMETERS
//  WINDOW_TICKS   31    max ticks from first to last arrival before the event is dropped (must be <= 31)
//  HOLDOFF_TICKS  4800  ticks after an event or drop during which onsets are ignored (echo rejection)
//  GEOM_MAX       24    largest physically plausible |delay| in ticks (used only with TDOA_GEOM_CHECK_EN)
//  CNT_W          16    width of the holdoff counter
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous active-low reset
//  sample_tick  in   1  one-clk strobe per audio sample; all onset sampling and counting advance only on it
//  onset_a      in   1  onset level from mic A detector
//  onset_b      in   1  onset level from mic B detector
//  onset_c      in   1  onset level from mic C detector
//  trigger      out  1  one-clk pulse: dAB/dAC hold a new measurement
//  dAB          out  6  signed, tB - tA in ticks, held until the next trigger
//  dAC          out  6  signed, tC - tA in ticks, held until the next trigger
//  busy         out  1  high in every state except IDLE
//  drop_cnt     out  8  saturating count of dropped events (timeouts, plus geometry rejects if enabled)
// BEHAVIOUR
//  Reset: trigger=0, dAB=0, dAC=0, busy=0, drop_cnt=0, state=IDLE, all arrival flags cleared.
//  Arrival = rising edge of the onset level, sampled on sample_tick (prev sample 0, this sample 1).
//  IDLE: on the first tick with any arrival, that tick is t=0. Every mic arriving on that tick records 0.
//    -> CAPTURE. Onsets already high at entry produce no arrival.
//  CAPTURE: window counter increments each tick. A mic's first arrival records the counter value.
//    Later edges from the same mic are ignored.
//    All three recorded -> COMPUTE on the next clk.
//    Counter reaches WINDOW_TICKS with any mic missing -> drop_cnt+1 (saturates at 255) -> HOLDOFF.
//    No trigger on a drop.
//  COMPUTE (one clk): form differences at 7 bits, then saturate to [-32,31].
//    Register dAB/dAC and pulse trigger; trigger is high on the clk after COMPUTE.
//    Latency from the sample_tick clk of the last arrival to trigger high = 2 clks.
//    -> HOLDOFF.
//  HOLDOFF: count HOLDOFF_TICKS ticks, ignoring all onsets -> IDLE. Edge history keeps updating,
//    so a level still high at exit causes no false arrival.
//  Simultaneous arrivals on one tick share a timestamp. A missing sample_tick freezes all counters.
//  rst_n asserted in any state aborts the event immediately. No partial trigger is ever emitted.
// CONFIGURATION
//  TDOA_GEOM_CHECK_EN defined: in COMPUTE, if |dAB|>GEOM_MAX or |dAC|>GEOM_MAX, no trigger,
//    drop_cnt+1, outputs keep previous values -> HOLDOFF.
//  Undefined: every complete event within the window triggers.
// STRUCTURE
//  tdoa_pkg: state enum {IDLE,CAPTURE,COMPUTE,HOLDOFF}; typedef logic signed [5:0] delay_t;
//    constants DELAY_MIN=-32, DELAY_MAX=31.
//  Sub-module arrival_latch, instantiated x3: edge detect, seen flag, 5-bit timestamp.
//    Inputs: clear/arm from the FSM, sample_tick, onset, window count.
// TESTING
//  1 A@t0, B@t5, C@t12 -> trigger once, 2 clks after C's tick; dAB=5, dAC=12; busy then HOLDOFF.
//  2 C@t0, B@t3, A@t7 -> dAB=-4, dAC=-7; one trigger pulse.
//  3 A,B,C rise on the same tick -> dAB=0, dAC=0.
//  4 A@t0, B@t2, C never -> no trigger; drop_cnt 0->1 after 31 ticks; IDLE after HOLDOFF_TICKS more ticks.
//  5 Extra A/B edges during HOLDOFF, then a fresh event -> extra edges ignored; the new event measured correctly.
//  6 rst_n low mid-CAPTURE -> all outputs at reset values; next event A@t0,B@t1,C@t2 gives dAB=1, dAC=2.
//    With TDOA_GEOM_CHECK_EN, A@t0,B@t28,C@t1 -> dropped, drop_cnt+1; without it, trigger with dAB=28.

Source files
------------

// File: rtl/tdoa_pkg.sv
// Shared types, constants and helpers for the TDOA estimator.
// The optional geometry check is enabled with the TDOA_GEOM_CHECK_EN macro.
package tdoa_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMPUTE = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    typedef logic signed [5:0] delay_t;

    localparam logic signed [6:0] DELAY_MIN = -7'sd32;
    localparam logic signed [6:0] DELAY_MAX = 7'sd31;

    function automatic delay_t sat_delay(input logic signed [6:0] d);
        delay_t r;
        if (d > DELAY_MAX) begin
            r = 6'sb011111;
        end else if (d < DELAY_MIN) begin
            r = 6'sb100000;
        end else begin
            r = d[5:0];
        end
        return r;
    endfunction

    function automatic logic [6:0] abs7(input logic signed [6:0] d);
        logic [6:0] r;
        if (d < 7'sd0) begin
            r = 7'(-d);
        end else begin
            r = 7'(d);
        end
        return r;
    endfunction

endpackage

// File: rtl/arrival_latch.sv
// Per-microphone onset edge detector with a first-arrival flag and a 5-bit timestamp.
module arrival_latch (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       arm,
    input  logic       sample_tick,
    input  logic       onset,
    input  logic [4:0] win_cnt,
    output logic       arrival,
    output logic       seen,
    output logic [4:0] ts
);

    logic prev_r;
    logic seen_r;
    logic [4:0] ts_r;

    assign arrival = sample_tick & onset & ~prev_r;
    assign seen    = seen_r;
    assign ts      = ts_r;

    // Edge history always tracks the level so a level held across HOLDOFF never looks like a new edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= 1'b0;
            seen_r <= 1'b0;
            ts_r   <= 5'd0;
        end else begin
            if (sample_tick) begin
                prev_r <= onset;
            end
            if (clear) begin
                seen_r <= 1'b0;
                ts_r   <= 5'd0;
            end else if (arm && arrival && !seen_r) begin
                seen_r <= 1'b1;
                ts_r   <= win_cnt;
            end
        end
    end

endmodule

// File: rtl/tdoa_estimator.sv
// Timestamps onsets from mics A/B/C and emits signed delays tB-tA and tC-tA with a one-clk trigger.
// Optional macro TDOA_GEOM_CHECK_EN rejects events whose delays exceed GEOM_MAX.
module tdoa_estimator
    import tdoa_pkg::*;
#(
    parameter int WINDOW_TICKS  = 31,
    parameter int HOLDOFF_TICKS = 4800,
    parameter int GEOM_MAX      = 24,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_tick,
    input  logic       onset_a,
    input  logic       onset_b,
    input  logic       onset_c,
    output logic       trigger,
    output delay_t     dAB,
    output delay_t     dAC,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    localparam logic [4:0]       WIN_LIM  = 5'(WINDOW_TICKS);
    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLDOFF_TICKS - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [4:0]       win_cnt_r;
    logic [CNT_W-1:0] hold_cnt_r;
    logic             trigger_r;
    delay_t           dab_r;
    delay_t           dac_r;
    logic [7:0]       drop_cnt_r;

    logic             clear_s;
    logic             arm_s;
    logic [4:0]       cur_t_s;
    logic [2:0]       arr_s;
    logic [2:0]       seen_s;
    logic [4:0]       ts_a_s;
    logic [4:0]       ts_b_s;
    logic [4:0]       ts_c_s;
    logic signed [6:0] diff_ab_s;
    logic signed [6:0] diff_ac_s;
    logic             geom_bad_s;
    logic             timeout_s;
    logic             trig_ok_s;
    logic             drop_s;

    // Latch control: the tick that leaves IDLE is t=0, later ticks are one past the last counted tick.
    always_comb begin
        clear_s = (state_r == HOLDOFF);
        arm_s   = (state_r == IDLE) || ((state_r == CAPTURE) && (win_cnt_r < WIN_LIM));
        if (state_r == IDLE) begin
            cur_t_s = 5'd0;
        end else begin
            cur_t_s = win_cnt_r + 5'd1;
        end
    end

    arrival_latch u_lat_a (
        .clk(clk), .rst_n(rst_n), .clear(clear_s), .arm(arm_s), .sample_tick(sample_tick),
        .onset(onset_a), .win_cnt(cur_t_s), .arrival(arr_s[0]), .seen(seen_s[0]), .ts(ts_a_s)
    );

    arrival_latch u_lat_b (
        .clk(clk), .rst_n(rst_n), .clear(clear_s), .arm(arm_s), .sample_tick(sample_tick),
        .onset(onset_b), .win_cnt(cur_t_s), .arrival(arr_s[1]), .seen(seen_s[1]), .ts(ts_b_s)
    );

    arrival_latch u_lat_c (
        .clk(clk), .rst_n(rst_n), .clear(clear_s), .arm(arm_s), .sample_tick(sample_tick),
        .onset(onset_c), .win_cnt(cur_t_s), .arrival(arr_s[2]), .seen(seen_s[2]), .ts(ts_c_s)
    );

    // Delay arithmetic at 7 bits, plus the accept/drop decision for the current clk.
    always_comb begin
        diff_ab_s = $signed({2'b00, ts_b_s}) - $signed({2'b00, ts_a_s});
        diff_ac_s = $signed({2'b00, ts_c_s}) - $signed({2'b00, ts_a_s});
`ifdef TDOA_GEOM_CHECK_EN
        geom_bad_s = (abs7(diff_ab_s) > 7'(GEOM_MAX)) || (abs7(diff_ac_s) > 7'(GEOM_MAX));
`else
        geom_bad_s = 1'b0;
`endif
        timeout_s = (state_r == CAPTURE) && !(&seen_s) && (win_cnt_r >= WIN_LIM);
        trig_ok_s = (state_r == COMPUTE) && !geom_bad_s;
        drop_s    = timeout_s || ((state_r == COMPUTE) && geom_bad_s);
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (sample_tick && (|arr_s)) begin
                    state_nxt_s = CAPTURE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CAPTURE: begin
                if (&seen_s) begin
                    state_nxt_s = COMPUTE;
                end else if (timeout_s) begin
                    state_nxt_s = HOLDOFF;
                end else begin
                    state_nxt_s = CAPTURE;
                end
            end
            COMPUTE: begin
                state_nxt_s = HOLDOFF;
            end
            HOLDOFF: begin
                if (sample_tick && (hold_cnt_r == HOLD_END)) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLDOFF;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Window and holdoff counters advance only on sample ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_r  <= 5'd0;
            hold_cnt_r <= '0;
        end else begin
            if (state_r != CAPTURE) begin
                win_cnt_r <= 5'd0;
            end else if (sample_tick && (win_cnt_r < WIN_LIM)) begin
                win_cnt_r <= win_cnt_r + 5'd1;
            end
            if (state_r != HOLDOFF) begin
                hold_cnt_r <= '0;
            end else if (sample_tick) begin
                hold_cnt_r <= hold_cnt_r + 1'b1;
            end
        end
    end

    // Registered measurement outputs and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trigger_r  <= 1'b0;
            dab_r      <= 6'sd0;
            dac_r      <= 6'sd0;
            drop_cnt_r <= 8'd0;
        end else begin
            trigger_r <= trig_ok_s;
            if (trig_ok_s) begin
                dab_r <= sat_delay(diff_ab_s);
                dac_r <= sat_delay(diff_ac_s);
            end
            if (drop_s && (drop_cnt_r != 8'hff)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end
        end
    end

    assign trigger  = trigger_r;
    assign dAB      = dab_r;
    assign dAC      = dac_r;
    assign drop_cnt = drop_cnt_r;
    assign busy     = (state_r != IDLE);

endmodule

// File: tb/tb_tdoa_estimator.sv
// Directed, table-driven bench for tdoa_estimator with hand-computed delays and drop counts.
module tb_tdoa_estimator;

    localparam int HOLD = 40;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sample_tick = 1'b0;
    logic              onset_a = 1'b0;
    logic              onset_b = 1'b0;
    logic              onset_c = 1'b0;
    logic              trigger;
    logic signed [5:0] dab_w;
    logic signed [5:0] dac_w;
    logic              busy;
    logic [7:0]        drop_cnt;

    tdoa_estimator #(.HOLDOFF_TICKS(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
        .onset_a(onset_a), .onset_b(onset_b), .onset_c(onset_c),
        .trigger(trigger), .dAB(dab_w), .dAC(dac_w), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int trig_cnt = 0;
    int trig_cyc = -100;
    int exp_dab  = 0;
    int exp_dac  = 0;
    int exp_drop = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (trigger) begin
            trig_cnt <= trig_cnt + 1;
            trig_cyc <= cyc;
        end
    end

    typedef struct {
        int ta;
        int tb;
        int tc;
        bit trig;
        int dab;
        int dac;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge with onsets already set; returns the cycle count just after the tick edge.
    task automatic tick(output int c);
        sample_tick = 1'b1;
        @(negedge clk);
        c = cyc;
        sample_tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle(input string name, input int exp_ticks);
        int k;
        int c;
        k = 0;
        onset_a = 1'b0;
        onset_b = 1'b0;
        onset_c = 1'b0;
        while (busy && k < 200) begin
            tick(c);
            k++;
        end
        check({name, " idle"}, int'(busy), 0);
        check({name, " holdoff ticks"}, k, exp_ticks);
    endtask

    // Runs one event; returns the number of ticks spent in HOLDOFF within the event loop.
    task automatic do_vector(input string name, input vec_t v, output int used);
        int mx;
        int n;
        int last_c;
        int end_t;
        int c;
        int trig0;
        bit late;
        trig0 = trig_cnt;
        mx = v.ta;
        if (v.tb > mx) mx = v.tb;
        if (v.tc > mx) mx = v.tc;
        late  = (v.ta < 0) || (v.tb < 0) || (v.tc < 0) || (mx > 31);
        n     = late ? 34 : mx + 1;
        end_t = late ? 31 : mx;
        last_c = -1;
        for (int t = 0; t < n; t++) begin
            onset_a = (v.ta >= 0) && (t >= v.ta);
            onset_b = (v.tb >= 0) && (t >= v.tb);
            onset_c = (v.tc >= 0) && (t >= v.tc);
            tick(c);
            if (t == mx) last_c = c;
        end
        if (v.trig) begin
            exp_dab = v.dab;
            exp_dac = v.dac;
        end else begin
            exp_drop++;
        end
        check({name, " trigger count"}, trig_cnt - trig0, v.trig ? 1 : 0);
        if (v.trig) check({name, " latency"}, trig_cyc - last_c, 2);
        check({name, " dAB"}, int'(dab_w), exp_dab);
        check({name, " dAC"}, int'(dac_w), exp_dac);
        check({name, " drop_cnt"}, int'(drop_cnt), exp_drop);
        check({name, " busy"}, int'(busy), 1);
        used = n - 1 - end_t;
    endtask

    vec_t vecs[8];

    initial begin
        int used;
        int c;
        int trig0;
        vecs[0] = '{0, 5, 12, 1'b1, 5, 12};
        vecs[1] = '{7, 3, 0, 1'b1, -4, -7};
        vecs[2] = '{0, 0, 0, 1'b1, 0, 0};
        vecs[3] = '{0, 2, -1, 1'b0, 0, 0};
`ifdef TDOA_GEOM_CHECK_EN
        vecs[4] = '{0, 28, 1, 1'b0, 0, 0};
`else
        vecs[4] = '{0, 28, 1, 1'b1, 28, 1};
`endif
        vecs[5] = '{0, 31, 31, 1'b1, 31, 31};
        vecs[6] = '{31, 0, 0, 1'b1, -31, -31};
        vecs[7] = '{0, 1, 32, 1'b0, 0, 0};

        repeat (3) @(negedge clk);
        check("reset trigger", int'(trigger), 0);
        check("reset dAB", int'(dab_w), 0);
        check("reset dAC", int'(dac_w), 0);
        check("reset busy", int'(busy), 0);
        check("reset drop_cnt", int'(drop_cnt), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_vector($sformatf("vec%0d", i), vecs[i], used);
            wait_idle($sformatf("vec%0d", i), HOLD - used);
        end

        // Extra edges during HOLDOFF must be ignored, then a fresh event is measured.
        do_vector("hold evt", vecs[0], used);
        trig0 = trig_cnt;
        for (int k = 0; k < 10; k++) begin
            onset_a = k[0];
            onset_b = ~k[0];
            tick(c);
        end
        check("hold extra edges trigger", trig_cnt - trig0, 0);
        check("hold extra edges dAB", int'(dab_w), 5);
        wait_idle("hold evt", HOLD - 10);
        do_vector("post hold", '{0, 3, 9, 1'b1, 3, 9}, used);
        wait_idle("post hold", HOLD - used);

        // Reset mid-CAPTURE aborts the event.
        onset_a = 1'b1;
        tick(c);
        tick(c);
        onset_b = 1'b1;
        tick(c);
        check("capture busy", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        exp_dab = 0;
        exp_dac = 0;
        exp_drop = 0;
        check("abort trigger", int'(trigger), 0);
        check("abort dAB", int'(dab_w), 0);
        check("abort dAC", int'(dac_w), 0);
        check("abort busy", int'(busy), 0);
        check("abort drop_cnt", int'(drop_cnt), 0);
        onset_a = 1'b0;
        onset_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tick(c);
        check("after abort idle", int'(busy), 0);
        do_vector("after abort", '{0, 1, 2, 1'b1, 1, 2}, used);
        wait_idle("after abort", HOLD - used);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
